// File: rtl/tsn_gcl_pkg.sv
// Shared definitions for the time-aware gate control list (GCL) executor:
// FSM state encoding, default geometry and the GCL entry record.
package tsn_gcl_pkg;

    localparam int DEF_NUM_ENTRIES   = 8;
    localparam int DEF_NUM_QUEUES    = 8;
    localparam int DEF_INTERVAL_W    = 24;
    localparam int DEF_CLK_PERIOD_NS = 8;

    typedef enum logic [1:0] {
        IDLE,
        EXECUTE,
        DELAY,
        END_OF_CYCLE
    } gcl_state_e;

    typedef struct packed {
        logic [DEF_NUM_QUEUES-1:0] gates;
        logic [DEF_INTERVAL_W-1:0] interval;
    } gcl_entry_t;

endpackage

// File: rtl/gcl_entry_ram.sv
// GCL entry storage: one write port, one registered read port with
// write-through so a write lands in the read register a clock later.
module gcl_entry_ram #(
    parameter int                DEPTH      = 8,
    parameter int                WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_WORD = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_WORD;
            end
            rdata <= RESET_WORD;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/gcl_execute_sm.sv
// Gate control list executor: steps through the GCL entries once per cycle,
// driving each entry's gate bits for its interval with no gap between entries.
module gcl_execute_sm
    import tsn_gcl_pkg::*;
#(
    parameter int NUM_ENTRIES   = DEF_NUM_ENTRIES,
    parameter int NUM_QUEUES    = DEF_NUM_QUEUES,
    parameter int INTERVAL_W    = DEF_INTERVAL_W,
    parameter int CLK_PERIOD_NS = DEF_CLK_PERIOD_NS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           gate_enable,
    input  logic                           cycle_start,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_addr,
    input  logic [NUM_QUEUES-1:0]          cfg_gate_states,
    input  logic [INTERVAL_W-1:0]          cfg_interval,
    input  logic [$clog2(NUM_ENTRIES):0]   cfg_list_len,
    output logic [NUM_QUEUES-1:0]          gate_states,
    output logic [$clog2(NUM_ENTRIES)-1:0] entry_index,
    output logic                           cycle_done
);

    localparam int IDX_W   = $clog2(NUM_ENTRIES);
    localparam int LEN_W   = IDX_W + 1;
    localparam int ENTRY_W = NUM_QUEUES + INTERVAL_W;
    localparam logic [INTERVAL_W-1:0] PERIOD  = INTERVAL_W'(CLK_PERIOD_NS);
    localparam logic [LEN_W-1:0]      MAX_LEN = LEN_W'(NUM_ENTRIES);

    gcl_state_e             state;
    logic [INTERVAL_W-1:0]  exit_timer;
    logic [IDX_W-1:0]       rd_addr;
    logic [ENTRY_W-1:0]     rd_entry;
    logic [NUM_QUEUES-1:0]  rd_gates;
    logic [INTERVAL_W-1:0]  rd_interval;
    logic [LEN_W-1:0]       eff_len;
    logic                   expire;
    logic                   last_entry;

    function automatic logic [INTERVAL_W-1:0] sat_sub(input logic [INTERVAL_W-1:0] a,
                                                      input logic [INTERVAL_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_ENTRIES - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    assign eff_len     = (cfg_list_len > MAX_LEN) ? MAX_LEN : cfg_list_len;
    assign expire      = (state == DELAY) && (exit_timer <= PERIOD);
    assign last_entry  = ({1'b0, entry_index} + LEN_W'(1)) >= eff_len;
    assign rd_gates    = rd_entry[ENTRY_W-1:INTERVAL_W];
    assign rd_interval = rd_entry[INTERVAL_W-1:0];

    // The RAM read is registered, so the address names the entry that the
    // load one clock after this one will need.
    always_comb begin
        rd_addr = '0;
        if (state == EXECUTE) begin
            rd_addr = wrap_inc('0);
        end else if (cycle_start) begin
            rd_addr = '0;
        end else if (state == DELAY) begin
            rd_addr = expire ? wrap_inc(wrap_inc(entry_index)) : wrap_inc(entry_index);
        end
    end

    gcl_entry_ram #(
        .DEPTH      (NUM_ENTRIES),
        .WIDTH      (ENTRY_W),
        .RESET_WORD ({{NUM_QUEUES{1'b1}}, {INTERVAL_W{1'b0}}})
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata ({cfg_gate_states, cfg_interval}),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gate_states <= '1;
            entry_index <= '0;
            cycle_done  <= 1'b0;
            exit_timer  <= '0;
        end else begin
            cycle_done <= 1'b0;
            if (!gate_enable) begin
                state       <= IDLE;
                gate_states <= '1;
                entry_index <= '0;
                exit_timer  <= '0;
            end else begin
                case (state)
                    IDLE, END_OF_CYCLE: begin
                        if (cycle_start && (eff_len != '0)) begin
                            state       <= EXECUTE;
                            entry_index <= '0;
                        end
                    end
                    EXECUTE: begin
                        gate_states <= rd_gates;
                        exit_timer  <= rd_interval;
                        entry_index <= '0;
                        state       <= DELAY;
                    end
                    DELAY: begin
                        // A restart beats a coincident expiry and never reports cycle_done.
                        if (cycle_start) begin
                            entry_index <= '0;
                            if (eff_len != '0) begin
                                state <= EXECUTE;
                            end else begin
                                state       <= IDLE;
                                gate_states <= '1;
                            end
                        end else if (expire) begin
                            if (last_entry) begin
                                cycle_done <= 1'b1;
                                state      <= END_OF_CYCLE;
                            end else begin
                                gate_states <= rd_gates;
                                exit_timer  <= rd_interval;
                                entry_index <= entry_index + IDX_W'(1);
                            end
                        end else begin
                            exit_timer <= sat_sub(exit_timer, PERIOD);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gcl_execute_sm.sv
// Bench for gcl_execute_sm: directed scenarios plus a randomized phase, all
// compared every clock against a hold-count model of the gate schedule.
module tb_gcl_execute_sm;
    import tsn_gcl_pkg::*;

    localparam int NE = 8;
    localparam int NQ = 8;
    localparam int IW = 24;
    localparam int CP = 8;

    localparam int M_IDLE  = 0;
    localparam int M_START = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          gate_enable = 1'b0;
    logic          cycle_start = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [NQ-1:0] cfg_gate_states = '0;
    logic [IW-1:0] cfg_interval = '0;
    logic [3:0]    cfg_list_len = '0;
    logic [NQ-1:0] gate_states;
    logic [2:0]    entry_index;
    logic          cycle_done;

    int checks = 0;
    int failures = 0;

    gcl_entry_t    ram_m [NE];
    int            m_mode, m_idx, m_left;
    logic [NQ-1:0] m_gates;
    logic          m_done;

    int   cnt_a, cnt_b, cnt_c, done_cnt, max_idx;
    logic seen_done;

    gcl_execute_sm #(
        .NUM_ENTRIES   (NE),
        .NUM_QUEUES    (NQ),
        .INTERVAL_W    (IW),
        .CLK_PERIOD_NS (CP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .gate_enable     (gate_enable),
        .cycle_start     (cycle_start),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_gate_states (cfg_gate_states),
        .cfg_interval    (cfg_interval),
        .cfg_list_len    (cfg_list_len),
        .gate_states     (gate_states),
        .entry_index     (entry_index),
        .cycle_done      (cycle_done)
    );

    always #5 clk = ~clk;

    function automatic int hold_clks(input int ns);
        return (ns == 0) ? 1 : (ns + CP - 1) / CP;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_idx   = 0;
        m_left  = 0;
        m_gates = '1;
        m_done  = 1'b0;
        for (int i = 0; i < NE; i++) begin
            ram_m[i].gates    = '1;
            ram_m[i].interval = '0;
        end
    endtask

    // Loads see the table as it stood before this edge's write.
    task automatic model_step();
        int eff;
        if (reset) begin
            model_reset();
        end else begin
            eff    = (int'(cfg_list_len) > NE) ? NE : int'(cfg_list_len);
            m_done = 1'b0;
            if (!gate_enable) begin
                m_mode  = M_IDLE;
                m_gates = '1;
                m_idx   = 0;
            end else begin
                case (m_mode)
                    M_IDLE, M_DONE: begin
                        if (cycle_start && eff > 0) begin
                            m_mode = M_START;
                            m_idx  = 0;
                        end
                    end
                    M_START: begin
                        m_idx   = 0;
                        m_gates = ram_m[0].gates;
                        m_left  = hold_clks(int'(ram_m[0].interval));
                        m_mode  = M_RUN;
                    end
                    default: begin
                        if (cycle_start) begin
                            m_idx = 0;
                            if (eff > 0) m_mode = M_START;
                            else begin
                                m_mode  = M_IDLE;
                                m_gates = '1;
                            end
                        end else if (m_left <= 1) begin
                            if (m_idx + 1 >= eff) begin
                                m_done = 1'b1;
                                m_mode = M_DONE;
                            end else begin
                                m_idx   = m_idx + 1;
                                m_gates = ram_m[m_idx].gates;
                                m_left  = hold_clks(int'(ram_m[m_idx].interval));
                            end
                        end else begin
                            m_left = m_left - 1;
                        end
                    end
                endcase
            end
            if (cfg_we) begin
                ram_m[cfg_addr].gates    = cfg_gate_states;
                ram_m[cfg_addr].interval = cfg_interval;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("model_gates", 32'(gate_states), 32'(m_gates));
        chk("model_index", 32'(entry_index), 32'(m_idx));
        chk("model_done",  32'(cycle_done),  32'(m_done));
    endtask

    task automatic wr(input int a, input int g, input int iv);
        cfg_we          = 1'b1;
        cfg_addr        = 3'(a);
        cfg_gate_states = 8'(g);
        cfg_interval    = 24'(iv);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        cycle_start = 1'b1;
        step();
        cycle_start = 1'b0;
    endtask

    task automatic clear_counts();
        cnt_a = 0; cnt_b = 0; cnt_c = 0; done_cnt = 0; max_idx = 0;
        seen_done = 1'b0;
    endtask

    task automatic run(input int n, input logic [NQ-1:0] a, input logic [NQ-1:0] b,
                       input logic [NQ-1:0] c);
        for (int i = 0; i < n; i++) begin
            step();
            if (cycle_done) begin
                done_cnt++;
                seen_done = 1'b1;
            end
            if (!seen_done) begin
                if (gate_states == a) cnt_a++;
                if (gate_states == b) cnt_b++;
                if (gate_states == c) cnt_c++;
            end
            if (int'(entry_index) > max_idx) max_idx = int'(entry_index);
        end
    endtask

    initial begin
        model_reset();
        step();
        chk("reset_gates", 32'(gate_states), 32'hFF);
        chk("reset_index", 32'(entry_index), 32'h0);
        chk("reset_done",  32'(cycle_done),  32'h0);
        reset = 1'b0;
        gate_enable = 1'b1;
        step();

        // Three-entry schedule 24/16/8 ns
        cfg_list_len = 4'd3;
        wr(0, 'h01, 24);
        wr(1, 'h02, 16);
        wr(2, 'h04, 8);
        pulse_start();
        clear_counts();
        run(10, 8'h01, 8'h02, 8'h04);
        chk("sched_hold01", cnt_a, 3);
        chk("sched_hold02", cnt_b, 2);
        chk("sched_hold04", cnt_c, 1);
        chk("sched_done_once", done_cnt, 1);
        chk("sched_last_held", 32'(gate_states), 32'h04);

        // Non-multiple and zero intervals
        gate_enable = 1'b0;
        step();
        gate_enable = 1'b1;
        cfg_list_len = 4'd1;
        wr(0, 'h5A, 10);
        pulse_start();
        clear_counts();
        run(6, 8'h5A, 8'h00, 8'h00);
        chk("interval10_hold", cnt_a, 2);
        wr(0, 'hA5, 0);
        pulse_start();
        clear_counts();
        run(6, 8'hA5, 8'h00, 8'h00);
        chk("interval0_hold", cnt_a, 1);

        // Truncation of a long entry; a write to it waits for the reload
        cfg_list_len = 4'd3;
        wr(0, 'h11, 800);
        wr(1, 'h22, 16);
        wr(2, 'h33, 8);
        pulse_start();
        clear_counts();
        run(20, 8'h11, 8'h00, 8'h00);
        chk("long_entry0", cnt_a, 20);
        wr(0, 'h99, 800);
        run(19, 8'h11, 8'h00, 8'h00);
        chk("write_deferred", 32'(gate_states), 32'h11);
        pulse_start();
        chk("trunc_index0", 32'(entry_index), 32'h0);
        clear_counts();
        run(20, 8'h99, 8'h00, 8'h00);
        chk("trunc_reload", cnt_a, 20);
        chk("trunc_no_done", done_cnt, 0);

        // Gate enable drop mid-entry, then an ignored start
        gate_enable = 1'b0;
        step();
        chk("disable_ff", 32'(gate_states), 32'hFF);
        pulse_start();
        clear_counts();
        run(4, 8'hFF, 8'h00, 8'h00);
        chk("disabled_start_ignored", cnt_a, 4);
        gate_enable = 1'b1;

        // Asynchronous reset mid-entry
        pulse_start();
        run(5, 8'h99, 8'h00, 8'h00);
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset_gates", 32'(gate_states), 32'hFF);
        chk("async_reset_index", 32'(entry_index), 32'h0);
        chk("async_reset_done",  32'(cycle_done),  32'h0);
        step();
        reset = 1'b0;
        clear_counts();
        run(4, 8'hFF, 8'h00, 8'h00);
        chk("post_reset_idle", cnt_a, 4);
        cfg_list_len = 4'd1;
        pulse_start();
        clear_counts();
        run(4, 8'hFF, 8'h00, 8'h00);
        chk("ram_reset_entry_done", done_cnt, 1);
        wr(0, 'h3C, 800);
        pulse_start();
        run(3, 8'h00, 8'h00, 8'h00);
        chk("post_reset_entry0", 32'(gate_states), 32'h3C);

        // List length limits
        gate_enable = 1'b0;
        step();
        gate_enable = 1'b1;
        cfg_list_len = 4'd0;
        pulse_start();
        clear_counts();
        run(4, 8'hFF, 8'h00, 8'h00);
        chk("len0_gates_open", cnt_a, 4);
        chk("len0_no_done", done_cnt, 0);
        cfg_list_len = 4'd12;
        for (int i = 0; i < NE; i++) wr(i, 1 << i, 8);
        pulse_start();
        clear_counts();
        run(14, 8'h00, 8'h00, 8'h00);
        chk("len12_max_index", max_idx, 7);
        chk("len12_done_once", done_cnt, 1);
        chk("len12_last_gates", 32'(gate_states), 32'h80);

        // Randomized traffic
        cfg_list_len = 4'd4;
        for (int i = 0; i < 600; i++) begin
            cycle_start     = ($urandom_range(0, 24) == 0);
            gate_enable     = ($urandom_range(0, 99) != 0);
            cfg_we          = ($urandom_range(0, 5) == 0);
            cfg_addr        = 3'($urandom_range(0, 7));
            cfg_gate_states = 8'($urandom);
            cfg_interval    = 24'($urandom_range(0, 50));
            if ($urandom_range(0, 39) == 0) cfg_list_len = 4'($urandom_range(0, 12));
            step();
        end
        cycle_start = 1'b0;
        cfg_we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcl_execute_sm.md
GCL_EXECUTE_SM -- requirements
Module: gcl_execute_sm

Interface
REQ-001 Parameter NUM_ENTRIES, default 8: gate control list (GCL) depth.
REQ-002 Parameter NUM_QUEUES, default 8: number of gate bits per entry.
REQ-003 Parameter INTERVAL_W, default 24: width of the time-interval field, in ns.
REQ-004 Parameter CLK_PERIOD_NS, default 8: ns elapsed per clk.
REQ-005 Port clk, input, 1: 125 MHz clock.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port gate_enable, input, 1: gating active; when 0, all gates open.
REQ-008 Port cycle_start, input, 1: one-clk pulse from the upstream cycle timer.
REQ-009 Port cfg_we, input, 1: GCL entry write strobe.
REQ-010 Port cfg_addr, input, clog2(NUM_ENTRIES): entry index to write.
REQ-011 Port cfg_gate_states, input, NUM_QUEUES: gate bits for the entry (1 = open).
REQ-012 Port cfg_interval, input, INTERVAL_W: entry duration in ns.
REQ-013 Port cfg_list_len, input, clog2(NUM_ENTRIES)+1: number of valid entries.
REQ-014 Port gate_states, output, NUM_QUEUES: operative gate states, registered.
REQ-015 Port entry_index, output, clog2(NUM_ENTRIES): index of the executing entry.
REQ-016 Port cycle_done, output, 1: one-clk pulse when the last entry expires.

Function
REQ-017 The FSM SHALL have states IDLE, EXECUTE, DELAY, END_OF_CYCLE.
REQ-018 IDLE: gate_states SHALL be all-ones; exit to EXECUTE on cycle_start when gate_enable=1 and effective length > 0.
REQ-019 Effective length SHALL be min(cfg_list_len, NUM_ENTRIES).
REQ-020 EXECUTE (one clk) SHALL load entry[idx]: gate_states <= gate bits, exit_timer <= interval, entry_index <= idx, then go to DELAY.
REQ-021 DELAY SHALL decrement exit_timer by CLK_PERIOD_NS each clk.
REQ-022 DELAY SHALL leave when exit_timer <= CLK_PERIOD_NS.
REQ-023 Each entry's gate_states SHALL be held for exactly max(1, ceil(interval/CLK_PERIOD_NS)) clks, with no gap between consecutive entries; the EXECUTE load overlaps the prior expiry.
REQ-024 On expiry of entry idx < len-1, the FSM SHALL advance to idx+1.
REQ-025 On expiry of entry len-1, it SHALL pulse cycle_done and enter END_OF_CYCLE, holding the last gate_states.
REQ-026 END_OF_CYCLE: cycle_start SHALL restart at entry 0.
REQ-027 cycle_start in DELAY (cycle truncation) SHALL restart at entry 0 on the next clk; truncation SHALL NOT produce a cycle_done pulse.
REQ-028 Interval 0 SHALL be treated as one clk.
REQ-029 Subtraction SHALL saturate at 0, with no wrap.
REQ-030 gate_enable=0 in any state SHALL force IDLE and all-ones gates on the next clk.
REQ-031 cfg_we SHALL write the GCL RAM in one clk.
REQ-032 A write to the currently executing entry SHALL take effect only at that entry's next load.
REQ-033 cfg_list_len changes SHALL be sampled at each load.
REQ-034 If the length drops to idx+1 or below mid-cycle, the current entry SHALL be treated as last.
REQ-035 If cycle_start and expiry occur in the same clk, cycle_start SHALL win: restart at entry 0, no cycle_done.

Reset
REQ-036 On reset: state = IDLE, gate_states = all-ones, entry_index = 0, cycle_done = 0, exit_timer = 0.
REQ-037 GCL RAM contents SHALL reset to gates all-ones and interval 0.
REQ-038 Reset asserted mid-DELAY SHALL abort immediately; after release the FSM SHALL wait in IDLE for cycle_start.

Structure
REQ-039 A shared package tsn_gcl_pkg SHALL hold the FSM state enum, the NUM_ENTRIES/NUM_QUEUES/INTERVAL_W/CLK_PERIOD_NS defaults, and the GCL entry record type.
REQ-040 The GCL storage SHALL be a sub-module gcl_entry_ram: 1 write port and 1 registered read port.
REQ-041 The read address SHALL be presented one clk ahead to meet REQ-023.

Verification
REQ-042 Three-entry list {0x01/24 ns, 0x02/16 ns, 0x04/8 ns}, len=3, cycle_start at T -> gates 0x01 for 3 clks, then 0x02 for 2, then 0x04 for 1; cycle_done pulses once; 0x04 held until the next cycle_start.
REQ-043 Entry 0 interval 10 ns -> held 2 clks; interval 0 -> held 1 clk.
REQ-044 Entry 0 interval 800 ns, cycle_start 40 clks into it -> entry_index returns to 0, gates reload, no cycle_done.
REQ-045 gate_enable drop mid-DELAY -> next clk gate_states = 0xFF and state IDLE; a later cycle_start with enable=0 is ignored.
REQ-046 Reset pulse mid-cycle -> all outputs at reset values within the same clk; after release, entry 0 starts only on the next cycle_start.
REQ-047 cfg_list_len = 0 with cycle_start -> stays IDLE, gates 0xFF; cfg_list_len = 12 -> executes 8 entries.
